// File: rtl/wino_pkg.sv
// wino_pkg: shared FSM state, tile geometry, default widths and packing helper for the Winograd output stage
package wino_pkg;
  typedef enum logic [1:0] {ACCUM, XF1, XF2, OUT} state_t;
  localparam int TILE_IN  = 4;
  localparam int TILE_OUT = 2;
  localparam int DEF_WP   = 24;
  localparam int DEF_WA   = 32;
  // element k = 4r+c sits at bits [(15-k)*w +: w], element 00 in the MSBs
  function automatic int elem_lsb(input int k, input int w);
    return (TILE_IN * TILE_IN - 1 - k) * w;
  endfunction
endpackage

// File: rtl/wino_output_transform_if.sv
// wino_output_transform_if: product-tile input and 2x2 output-tile handshakes
interface wino_output_transform_if #(
  parameter int WP = 24,
  parameter int WA = 32,
  parameter int WY = WA + 4
);
  logic [16*WP-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [4*WY-1:0]  out_data;
  logic             out_valid;
  logic             out_ready;
  modport master (output in_data, in_valid, in_last, out_ready, input in_ready, out_data, out_valid);
  modport slave  (input in_data, in_valid, in_last, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/wino_at_1d.sv
// wino_at_1d: 1-D A' transform, (a,b,c,d) -> (a+b+c, b-c-d)
module wino_at_1d #(
  parameter int W = 36
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] p,
  output logic signed [W-1:0] q
);
  assign p = a + b + c;
  assign q = b - c - d;
endmodule

// File: rtl/wino_output_transform.sv
// wino_output_transform: accumulates 4x4 product tiles over channels, then Y = A'.M.A per tile.
// Define WINO_OUT_RELU_EN to clamp each output element at zero.
module wino_output_transform
  import wino_pkg::*;
#(
  parameter int WP = DEF_WP,
  parameter int WA = DEF_WA
) (
  input logic clk,
  input logic rst,
  wino_output_transform_if.slave io
);
  localparam int WY = WA + 4;
  localparam int NE = TILE_IN * TILE_IN;
  localparam int NY = TILE_OUT * TILE_OUT;
  state_t state;
  logic first;
  logic signed [WA-1:0] acc  [NE];
  logic signed [WA-1:0] prod [NE];
  logic signed [WY-1:0] t    [TILE_OUT*TILE_IN];
  logic signed [WY-1:0] tn   [TILE_OUT*TILE_IN];
  logic signed [WY-1:0] y    [NY];
  logic signed [WY-1:0] yc   [NY];
  logic [4*WY-1:0] out_q;
  for (genvar k = 0; k < NE; k++) begin : g_prod
    assign prod[k] = WA'(signed'(io.in_data[elem_lsb(k, WP) +: WP]));
  end
  // column pass: T row 0 in tn[0..3], T row 1 in tn[4..7]
  for (genvar j = 0; j < TILE_IN; j++) begin : g_col
    wino_at_1d #(.W(WY)) u_col (
      .a(WY'(acc[j])),
      .b(WY'(acc[TILE_IN+j])),
      .c(WY'(acc[2*TILE_IN+j])),
      .d(WY'(acc[3*TILE_IN+j])),
      .p(tn[j]),
      .q(tn[TILE_IN+j])
    );
  end
  for (genvar i = 0; i < TILE_OUT; i++) begin : g_row
    wino_at_1d #(.W(WY)) u_row (
      .a(t[TILE_IN*i]),
      .b(t[TILE_IN*i+1]),
      .c(t[TILE_IN*i+2]),
      .d(t[TILE_IN*i+3]),
      .p(y[TILE_OUT*i]),
      .q(y[TILE_OUT*i+1])
    );
  end
  for (genvar k = 0; k < NY; k++) begin : g_clamp
`ifdef WINO_OUT_RELU_EN
    assign yc[k] = y[k][WY-1] ? '0 : y[k];
`else
    assign yc[k] = y[k];
`endif
  end
  assign io.in_ready  = state == ACCUM;
  assign io.out_valid = state == OUT;
  assign io.out_data  = out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      first <= 1'b1;
      acc   <= '{default: '0};
      t     <= '{default: '0};
      out_q <= '0;
    end else begin
      case (state)
        ACCUM: if (io.in_valid) begin
          for (int k = 0; k < NE; k++) acc[k] <= first ? prod[k] : acc[k] + prod[k];
          first <= 1'b0;
          if (io.in_last) state <= XF1;
        end
        XF1: begin
          t     <= tn;
          state <= XF2;
        end
        XF2: begin
          out_q <= {yc[0], yc[1], yc[2], yc[3]};
          state <= OUT;
        end
        default: if (io.out_ready) begin
          first <= 1'b1;
          state <= ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wino_output_transform.sv
// tb_wino_output_transform: directed table of tiles plus backpressure and reset sequences
module tb_wino_output_transform;
  localparam int WP = 24;
  localparam int WA = 32;
  localparam int WY = WA + 4;
  typedef struct {
    int beats;
    int fill;
    int only_k;
    longint exp_y [4];
  } vec_t;
  logic clk;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs [6];
  wino_output_transform_if #(.WP(WP), .WA(WA)) io ();
  wino_output_transform #(.WP(WP), .WA(WA)) dut (.clk(clk), .rst(rst), .io(io.slave));
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  function automatic longint rl(input longint x);
`ifdef WINO_OUT_RELU_EN
    return x < 0 ? 0 : x;
`else
    return x;
`endif
  endfunction
  function automatic logic [16*WP-1:0] mk(input int fill, input int only_k);
    logic [16*WP-1:0] d = '0;
    for (int k = 0; k < 16; k++)
      if (only_k < 0 || k == only_k) d[(15-k)*WP +: WP] = WP'(fill);
    return d;
  endfunction
  function automatic longint yo(input int i);
    logic signed [WY-1:0] v;
    v = io.out_data[(3-i)*WY +: WY];
    return longint'(v);
  endfunction
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic send(input logic [16*WP-1:0] d, input logic last);
    int k = 0;
    while (!io.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready_wait", longint'(io.in_ready), 1);
    io.in_data = d;
    io.in_valid = 1;
    io.in_last = last;
    @(posedge clk);
    #1;
    io.in_valid = 0;
    io.in_last = 0;
  endtask
  task automatic wait_out(input string name, input int want_lat);
    int k = 0;
    while (!io.out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_latency"}, k, want_lat);
  endtask
  task automatic check_y(input string name, input longint e0, input longint e1, input longint e2, input longint e3);
    chk({name, "_y00"}, yo(0), rl(e0));
    chk({name, "_y01"}, yo(1), rl(e1));
    chk({name, "_y10"}, yo(2), rl(e2));
    chk({name, "_y11"}, yo(3), rl(e3));
  endtask
  task automatic handshake(input string name);
    io.out_ready = 1;
    @(posedge clk);
    #1;
    io.out_ready = 0;
    chk({name, "_valid_drop"}, longint'(io.out_valid), 0);
    chk({name, "_ready_back"}, longint'(io.in_ready), 1);
  endtask
  initial begin
    longint m = -(longint'(1) <<< 23);
    logic [4*WY-1:0] held;
    vecs[0] = '{1, 1, -1, '{9, -3, -3, 1}};
    vecs[1] = '{2, 1, -1, '{18, -6, -6, 2}};
    vecs[2] = '{1, 5, 5, '{5, 5, 5, 5}};
    vecs[3] = '{1, int'(m), -1, '{9*m, -3*m, -3*m, m}};
    vecs[4] = '{1, 3, 0, '{3, 0, 0, 0}};
    vecs[5] = '{3, 2, 15, '{0, 0, 0, 6}};
    io.in_data = '0;
    io.in_valid = 0;
    io.in_last = 0;
    io.out_ready = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_in_ready", longint'(io.in_ready), 1);
    chk("reset_out_valid", longint'(io.out_valid), 0);
    chk("reset_out_data", longint'(io.out_data != '0), 0);
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vecs[v].beats; b++) send(mk(vecs[v].fill, vecs[v].only_k), b == vecs[v].beats - 1);
      wait_out($sformatf("vec%0d", v), 2);
      check_y($sformatf("vec%0d", v), vecs[v].exp_y[0], vecs[v].exp_y[1], vecs[v].exp_y[2], vecs[v].exp_y[3]);
      handshake($sformatf("vec%0d", v));
    end
    // backpressure with ignored beats of 7s offered throughout
    send(mk(1, -1), 1);
    wait_out("bp", 2);
    held = io.out_data;
    io.in_data = mk(7, -1);
    io.in_valid = 1;
    io.in_last = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid_c%0d", c), longint'(io.out_valid), 1);
      chk($sformatf("bp_in_ready_c%0d", c), longint'(io.in_ready), 0);
      chk($sformatf("bp_stable_c%0d", c), longint'(io.out_data == held), 1);
    end
    io.in_valid = 0;
    io.in_last = 0;
    check_y("bp", 9, -3, -3, 1);
    handshake("bp");
    send(mk(1, -1), 1);
    wait_out("bp_next", 2);
    check_y("bp_next", 9, -3, -3, 1);
    handshake("bp_next");
    // reset mid-tile discards the partial accumulation
    send(mk(7, -1), 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_tile_in_ready", longint'(io.in_ready), 1);
    send(mk(1, -1), 1);
    wait_out("rst_tile", 2);
    check_y("rst_tile", 9, -3, -3, 1);
    // reset while holding an output tile
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_out_valid", longint'(io.out_valid), 0);
    chk("rst_out_data", longint'(io.out_data != '0), 0);
    chk("rst_out_in_ready", longint'(io.in_ready), 1);
    // out_ready without out_valid has no effect, in_last without in_valid is ignored
    io.out_ready = 1;
    io.in_last = 1;
    repeat (2) @(posedge clk);
    #1;
    io.out_ready = 0;
    io.in_last = 0;
    chk("idle_in_ready", longint'(io.in_ready), 1);
    chk("idle_out_valid", longint'(io.out_valid), 0);
    send(mk(2, -1), 0);
    send(mk(1, -1), 1);
    wait_out("after_idle", 2);
    check_y("after_idle", 27, -9, -9, 3);
    handshake("after_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
